// File: rtl/fetch_unit.sv
// Front-end fetch stage: drives four consecutive word addresses into a 4-wide
// instruction cache and buffers the returned words in a circular queue for decode.
module fetch_unit #(
    parameter int          QUEUE_DEPTH = 16,
    parameter logic [15:1] RESET_PC    = 15'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [15:1] redirect_pc,
    output logic [15:1] pc_array     [0:3],
    input  logic [15:0] instructions [0:3],
    output logic [15:0] out_instr    [0:3],
    output logic [15:1] out_pc       [0:3],
    output logic [3:0]  out_valid,
    input  logic [2:0]  deq_count
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SUM_W = CNT_W + 2;

    localparam logic [SUM_W-1:0] DEPTH_S = SUM_W'(QUEUE_DEPTH);
    localparam logic [SUM_W-1:0] FOUR_S  = SUM_W'(4);
    localparam logic [CNT_W-1:0] FOUR_C  = CNT_W'(4);
    localparam logic [PTR_W-1:0] FOUR_P  = PTR_W'(4);

    logic [15:1]      fetch_pc;
    logic             inflight_valid;
    logic [15:1]      inflight_pc;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    logic [15:0] q_instr [QUEUE_DEPTH];
    logic [15:1] q_pc    [QUEUE_DEPTH];

    logic [SUM_W-1:0] demand;
    logic             issue;
    logic             enq;
    logic [CNT_W-1:0] enq_amount;

    // Reserve room for the request already in flight plus the one about to issue;
    // same-cycle dequeues are deliberately not credited.
    assign demand     = SUM_W'(count) + (inflight_valid ? FOUR_S : '0) + FOUR_S;
    assign issue      = !redirect_valid && (demand <= DEPTH_S);
    assign enq        = inflight_valid && !redirect_valid;
    assign enq_amount = enq ? FOUR_C : '0;

    genvar i;
    generate
        for (i = 0; i < 4; i++) begin : g_lanes
            assign pc_array[i]  = fetch_pc + 15'(i);
            assign out_instr[i] = q_instr[head + PTR_W'(i)];
            assign out_pc[i]    = q_pc[head + PTR_W'(i)];
            assign out_valid[i] = count > CNT_W'(i);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc       <= RESET_PC;
            inflight_valid <= 1'b0;
            inflight_pc    <= '0;
            head           <= '0;
            tail           <= '0;
            count          <= '0;
        end else if (redirect_valid) begin
            fetch_pc       <= redirect_pc;
            inflight_valid <= 1'b0;
            head           <= '0;
            tail           <= '0;
            count          <= '0;
        end else begin
            if (issue) begin
                inflight_valid <= 1'b1;
                inflight_pc    <= fetch_pc;
                fetch_pc       <= fetch_pc + 15'd4;
            end else begin
                inflight_valid <= 1'b0;
            end
            if (enq) begin
                tail <= tail + FOUR_P;
            end
            head  <= head + PTR_W'(deq_count);
            count <= count + enq_amount - CNT_W'(deq_count);
        end
    end

    // Storage carries no reset; out_valid alone qualifies what decode may use.
    always_ff @(posedge clk) begin
        if (!reset && enq) begin
            for (int k = 0; k < 4; k++) begin
                q_instr[tail + PTR_W'(k)] <= instructions[k];
                q_pc[tail + PTR_W'(k)]    <= inflight_pc + 15'(k);
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a behavioural cache, a program-order
// scoreboard of expected (pc, word) pairs, directed latency tests and random dequeue.
module tb_fetch_unit;

    typedef struct {
        logic [15:1] pc;
        logic [15:0] instr;
    } entry_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [15:1] redirect_pc;
    logic [2:0]  deq_count;
    logic [15:1] pc_array     [0:3];
    logic [15:0] instructions [0:3];
    logic [15:0] out_instr    [0:3];
    logic [15:1] out_pc       [0:3];
    logic [3:0]  out_valid;

    logic        redirect_valid2;
    logic [15:1] redirect_pc2;
    logic [2:0]  deq_count2;
    logic [15:1] pc_array2     [0:3];
    logic [15:0] instructions2 [0:3];
    logic [15:0] out_instr2    [0:3];
    logic [15:1] out_pc2       [0:3];
    logic [3:0]  out_valid2;

    int     checks = 0;
    int     passed = 0;
    entry_t sb[$];
    logic   flushed = 1'b1;
    int     empty_run = 0;

    always #5 clk = ~clk;

    fetch_unit #(.QUEUE_DEPTH(16), .RESET_PC(15'h0000)) dut (
        .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .pc_array(pc_array), .instructions(instructions), .out_instr(out_instr),
        .out_pc(out_pc), .out_valid(out_valid), .deq_count(deq_count)
    );

    fetch_unit #(.QUEUE_DEPTH(16), .RESET_PC(15'h7FFE)) dut_wrap (
        .clk(clk), .reset(reset), .redirect_valid(redirect_valid2), .redirect_pc(redirect_pc2),
        .pc_array(pc_array2), .instructions(instructions2), .out_instr(out_instr2),
        .out_pc(out_pc2), .out_valid(out_valid2), .deq_count(deq_count2)
    );

    function automatic logic [15:0] mem_word(input logic [15:1] a);
        logic [15:0] w;
        w = {a, 1'b1};
        return (w * 16'd13) ^ 16'h5A3C;
    endfunction

    function automatic entry_t make_entry(input logic [15:1] p);
        entry_t e;
        e.pc    = p;
        e.instr = mem_word(p);
        return e;
    endfunction

    function automatic bit is_thermo(input logic [3:0] v);
        return (v == 4'h0) || (v == 4'h1) || (v == 4'h3) || (v == 4'h7) || (v == 4'hF);
    endfunction

    function automatic int starve_len(input logic fl, input int run, input logic [3:0] v);
        if (v != 4'h0) return 0;
        return fl ? 1 : run + 1;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) passed++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    endtask

    task automatic refill(input logic [15:1] base);
        while (sb.size() < 8)
            sb.push_back(make_entry(sb.size() == 0 ? base : sb[sb.size()-1].pc + 15'd1));
    endtask

    // Cache with one-cycle read latency for both instances.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            instructions[i]  <= mem_word(pc_array[i]);
            instructions2[i] <= mem_word(pc_array2[i]);
        end
    end

    // Scoreboard: flushes start a new expected program-order stream, dequeues retire entries.
    always @(posedge clk) begin
        if (reset) begin
            sb.delete();
            refill(15'h0000);
            flushed <= 1'b1;
        end else if (redirect_valid) begin
            sb.delete();
            refill(redirect_pc);
            flushed <= 1'b1;
        end else begin
            for (int i = 0; i < int'(deq_count); i++)
                if (sb.size() > 0) void'(sb.pop_front());
            refill(15'h0000);
            flushed <= 1'b0;
        end
    end

    // Monitor: every presented entry must be the next expected one in program order.
    always @(negedge clk) begin
        checkOutput("out_valid_thermo", 32'(is_thermo(out_valid)), 32'd1);
        for (int i = 0; i < 4; i++) begin
            if (out_valid[i] === 1'b1 && sb.size() > i) begin
                checkOutput($sformatf("sb_pc[%0d]", i), 32'(out_pc[i]), 32'(sb[i].pc));
                checkOutput($sformatf("sb_instr[%0d]", i), 32'(out_instr[i]), 32'(sb[i].instr));
            end
        end
        checkOutput("no_starve", 32'(starve_len(flushed, empty_run, out_valid) <= 3), 32'd1);
        empty_run <= starve_len(flushed, empty_run, out_valid);
    end

    task automatic doReset(input logic with_redirect, input logic [15:1] rpc);
        reset          = 1'b1;
        redirect_valid = with_redirect;
        redirect_pc    = rpc;
        deq_count      = 3'd0;
        @(posedge clk);
        @(negedge clk);
        reset          = 1'b0;
        redirect_valid = 1'b0;
    endtask

    task automatic applyStimulus(input logic redir, input logic [15:1] rpc, input int deq);
        checkOutput("deq_legal", 32'(deq <= $countones(out_valid)), 32'd1);
        redirect_valid = redir;
        redirect_pc    = rpc;
        deq_count      = 3'(deq);
        @(posedge clk);
        @(negedge clk);
        redirect_valid = 1'b0;
        deq_count      = 3'd0;
    endtask

    initial begin
        int          steps [4];
        int          exp_pc0 [4];
        logic [15:1] e;
        int          d;
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; deq_count = '0;
        redirect_valid2 = 1'b0; redirect_pc2 = '0; deq_count2 = '0;
        @(negedge clk);

        $display("[TB] fill to full with no dequeue");
        doReset(1'b0, 15'h0);
        checkOutput("reset_out_valid", 32'(out_valid), 32'h0);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("reset_pc_array[%0d]", i), 32'(pc_array[i]), i);
            e = 15'h7FFE + 15'(i);
            checkOutput($sformatf("wrap_pc_array[%0d]", i), 32'(pc_array2[i]), 32'(e));
        end
        applyStimulus(1'b0, 15'h0, 0);
        for (int i = 0; i < 4; i++)
            checkOutput($sformatf("c1_pc_array[%0d]", i), 32'(pc_array[i]), 4 + i);
        checkOutput("c1_out_valid", 32'(out_valid), 32'h0);
        checkOutput("wrap_next_issue", 32'(pc_array2[0]), 32'h0002);
        applyStimulus(1'b0, 15'h0, 0);
        checkOutput("c2_out_valid", 32'(out_valid), 32'hF);
        for (int i = 0; i < 4; i++) begin
            e = 15'h7FFE + 15'(i);
            checkOutput($sformatf("c2_out_pc[%0d]", i), 32'(out_pc[i]), i);
            checkOutput($sformatf("wrap_out_pc[%0d]", i), 32'(out_pc2[i]), 32'(e));
            checkOutput($sformatf("wrap_out_instr[%0d]", i), 32'(out_instr2[i]), 32'(mem_word(e)));
        end
        repeat (3) applyStimulus(1'b0, 15'h0, 0);
        checkOutput("c5_fetch_stall", 32'(pc_array[0]), 32'h10);
        repeat (3) applyStimulus(1'b0, 15'h0, 0);
        checkOutput("c8_fetch_stall", 32'(pc_array[0]), 32'h10);
        for (int i = 0; i < 4; i++)
            checkOutput($sformatf("full_out_pc[%0d]", i), 32'(out_pc[i]), i);

        $display("[TB] drain full queue then steady 4/cycle");
        repeat (4) applyStimulus(1'b0, 15'h0, 4);
        checkOutput("drained_out_pc0", 32'(out_pc[0]), 32'h10);
        for (int k = 1; k <= 20; k++) begin
            applyStimulus(1'b0, 15'h0, 4);
            checkOutput("steady_out_valid", 32'(out_valid), 32'hF);
            checkOutput("steady_out_pc0", 32'(out_pc[0]), 32'h10 + 4 * k);
        end

        $display("[TB] uneven dequeue");
        doReset(1'b0, 15'h0);
        repeat (2) applyStimulus(1'b0, 15'h0, 0);
        steps   = '{1, 3, 2, 4};
        exp_pc0 = '{1, 4, 6, 10};
        checkOutput("uneven_start", 32'(out_pc[0]), 32'h0);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 15'h0, steps[k]);
            checkOutput($sformatf("uneven_out_pc0_%0d", k), 32'(out_pc[0]), exp_pc0[k]);
        end

        $display("[TB] redirect with full-ish queue and request in flight");
        doReset(1'b0, 15'h0);
        repeat (4) applyStimulus(1'b0, 15'h0, 0);
        checkOutput("pre_redirect_valid", 32'(out_valid), 32'hF);
        applyStimulus(1'b1, 15'h1234, 0);
        checkOutput("redir_t1_valid", 32'(out_valid), 32'h0);
        checkOutput("redir_t1_pc_array", 32'(pc_array[0]), 32'h1234);
        applyStimulus(1'b0, 15'h0, 0);
        checkOutput("redir_t2_valid", 32'(out_valid), 32'h0);
        applyStimulus(1'b0, 15'h0, 0);
        checkOutput("redir_t3_valid", 32'(out_valid), 32'hF);
        for (int i = 0; i < 4; i++)
            checkOutput($sformatf("redir_t3_out_pc[%0d]", i), 32'(out_pc[i]), 32'h1234 + i);

        $display("[TB] reset mid-stream with redirect also high");
        repeat (5) applyStimulus(1'b0, 15'h0, 2);
        doReset(1'b1, 15'h5555);
        checkOutput("rst_redir_valid", 32'(out_valid), 32'h0);
        checkOutput("rst_redir_pc_array", 32'(pc_array[0]), 32'h0);
        repeat (2) applyStimulus(1'b0, 15'h0, 0);
        checkOutput("rst_redir_out_valid", 32'(out_valid), 32'hF);
        checkOutput("rst_redir_out_pc0", 32'(out_pc[0]), 32'h0);

        $display("[TB] random dequeue and redirects");
        for (int k = 0; k < 400; k++) begin
            d = $urandom_range(0, $countones(out_valid));
            applyStimulus(($urandom_range(0, 19) == 0), 15'($urandom), d);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Front-end fetch stage wrapped around the 4-wide instruction cache. Generates the four consecutive word addresses presented to the cache each cycle and tracks the cache's one-cycle read latency. Captures the returned instruction words into a circular instruction queue with their PCs, and serves up to four oldest entries per cycle to decode. Handles back-pressure from decode and full flush on a redirect (branch/exception).

## Interface
Parameters:
- QUEUE_DEPTH, 16, instruction queue entries; power of two, at least 8.
- RESET_PC, 15'h0000, word address fetched first after reset.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- redirect_valid  input  1  flush and restart fetch this cycle.
- redirect_pc  input  [15:1]  new fetch word address; valid with redirect_valid.
- pc_array[0:3]  output  [15:1] each  word addresses to the cache; pc_array[i] = fetch_pc + i.
- instructions[0:3]  input  [15:0] each  cache read data, one cycle after pc_array.
- out_instr[0:3]  output  [15:0] each  queue entries head+0..head+3.
- out_pc[0:3]  output  [15:1] each  PCs of those entries.
- out_valid  output  [3:0]  bit i set iff queue count > i (thermometer).
- deq_count  input  [2:0]  entries decode consumes this cycle, 0..4.

## Operation
- State: fetch_pc[15:1], inflight_valid, inflight_pc[15:1], queue storage (instr, pc), head, tail, count (0..QUEUE_DEPTH).
- pc_array is combinational from fetch_pc and driven every cycle. The cache reads regardless; only issue bookkeeping is gated.
- Issue condition (no redirect): count + (inflight_valid ? 4 : 0) + 4 <= QUEUE_DEPTH. Uses the current count and ignores same-cycle dequeue (conservative).
- On issue: inflight_valid <= 1, inflight_pc <= fetch_pc, fetch_pc <= fetch_pc + 4.
- When the issue condition is false: inflight_valid <= 0, fetch_pc holds.
- Enqueue: when inflight_valid and no redirect, write instructions[i] with PC inflight_pc + i at tail + i for i = 0..3, and tail += 4.
- Dequeue: head += deq_count. deq_count greater than popcount(out_valid) is illegal; the bench asserts on it. Design behaviour is undefined.
- count_next = count + (enq ? 4 : 0) - deq_count. Simultaneous enqueue and dequeue are both applied.
- Redirect (priority over everything except reset):
  - head, tail and count go to 0; deq_count is ignored.
  - The arriving cache data is discarded; inflight_valid <= 0.
  - fetch_pc <= redirect_pc; no issue this cycle.
- Reset: fetch_pc = RESET_PC, inflight_valid = 0, head = tail = count = 0.
- Reset overrides redirect. Reset mid-operation drops all queued and in-flight data.
- Address arithmetic is modulo 2^15. fetch_pc + i and fetch_pc + 4 wrap, e.g. 7FFE -> 7FFE, 7FFF, 0000, 0001.
- Queue pointers wrap modulo QUEUE_DEPTH.
- out_instr and out_pc for indices at or beyond count are don't-care. out_valid is the only qualifier.

## Timing
- All outputs are registered state or combinational from registered state. No input-to-output combinational path, except pc_array depending on fetch_pc only.
- Reset values: out_valid = 0000; pc_array = RESET_PC + 0..3.
- Fetch latency, first cycle after reset deasserts = cycle 0:
  - cycle 0: issue of RESET_PC.
  - cycle 1: cache data returns and is enqueued at the end of the cycle.
  - cycle 2: out_valid = 1111.
- Redirect latency, redirect at cycle t:
  - cycle t+1: pc_array shows redirect_pc and is issued.
  - cycle t+2: data enqueued.
  - cycle t+3: out_valid = 1111 with out_pc[0] = redirect_pc.
- Sustained throughput: 4 instructions/cycle when decode drains 4/cycle.
  - Steady-state count stays at 4 or 8.
- Full: with deq_count = 0, the queue fills to exactly QUEUE_DEPTH and fetch stalls. No entry is lost or overwritten.
  - Issue resumes the cycle after count drops so that the issue condition holds.

## Test plan
- Reset, then deq_count = 0: pc_array = 0,1,2,3 then 4,5,6,7. After 5 cycles, count = 16 and out_pc = 0,1,2,3. fetch_pc stalls at 0x10 and no entry is overwritten.
- Steady drain of deq_count = 4 from cycle 2: out_pc advances by 4 every cycle with no bubbles. out_instr matches memory contents.
- Uneven dequeue of 1, 3, 2, 4: out_pc[0] steps 0, 1, 4, 6, 10. out_valid stays thermometer-coded.
- Redirect to 0x1234 while the queue holds 12 entries and a request is in flight: the next cycle shows out_valid = 0000. At t+3, out_pc = 1234..1237; stale data is never seen.
- Wrap: RESET_PC = 7FFE gives pc_array = 7FFE, 7FFF, 0000, 0001. The next issue is 0002.
- Reset asserted mid-stream with redirect_valid also high: out_valid = 0000. Fetch restarts from RESET_PC, not redirect_pc.
